// File: rtl/banco_pkg.sv
// Shared defaults and the register-index type for the parameterised register bank.
package banco_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;
endpackage

// File: rtl/scoreboard_regs.sv
// Pending-write scoreboard: one busy bit per architectural register, x0 never busy.
module scoreboard_regs
    import banco_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             set_en,
    input  logic [AW-1:0]    set_idx,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_idx,
    output logic [NREGS-1:0] busy
);

    // A new producer (set) overrides a completing write (clear) on the same register
    always_ff @(posedge CLK) begin
        if (RST) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (set_en && (set_idx == AW'(i))) begin
                    busy[i] <= 1'b1;
                end else if (clr_en && (clr_idx == AW'(i))) begin
                    busy[i] <= 1'b0;
                end else begin
                    busy[i] <= busy[i];
                end
            end
        end
    end

endmodule

// File: rtl/banco_registros_param.sv
// Register bank with NRD read ports, write-through bypass, optional registered read
// and a busy scoreboard that flags operands with a pending write.
module banco_registros_param
    import banco_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int READ_REG = 0,
    localparam int AW = $clog2(NREGS)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NRD-1:0][AW-1:0]   readReg,
    output logic [NRD-1:0][XLEN-1:0] readData,
    input  logic                     RegWrite,
    input  logic [AW-1:0]            writeReg,
    input  logic [XLEN-1:0]          writeData,
    input  logic                     issue_valid,
    input  logic [AW-1:0]            issue_rd,
    output logic [NRD-1:0]           rs_busy
);

    logic [NREGS-1:0][XLEN-1:0] registro_r;
    logic [NREGS-1:0]           busy_s;
    logic [NRD-1:0][XLEN-1:0]   rd_val_s;

    // Storage update; address 0 is never written so it stays at its reset value
    always_ff @(posedge CLK) begin
        if (RST) begin
            registro_r <= '0;
        end else if (RegWrite && (writeReg != '0)) begin
            registro_r[writeReg] <= writeData;
        end else begin
            registro_r <= registro_r;
        end
    end

    // Read mux with write-through bypass, and hazard flags cancelled by a same-cycle write
    always_comb begin
        rd_val_s = '0;
        rs_busy  = '0;
        for (int i = 0; i < NRD; i++) begin
            if (readReg[i] == '0) begin
                rd_val_s[i] = '0;
            end else if (RegWrite && (writeReg == readReg[i])) begin
                rd_val_s[i] = writeData;
            end else begin
                rd_val_s[i] = registro_r[readReg[i]];
            end
            rs_busy[i] = busy_s[readReg[i]] & ~(RegWrite & (writeReg == readReg[i]));
        end
    end

    generate
        if (READ_REG != 0) begin : g_reg_read
            logic [NRD-1:0][XLEN-1:0] read_data_r;

            // Registered read captures the bypassed value, so a write at the same edge is visible
            always_ff @(posedge CLK) begin
                if (RST) begin
                    read_data_r <= '0;
                end else begin
                    read_data_r <= rd_val_s;
                end
            end

            assign readData = read_data_r;
        end else begin : g_comb_read
            assign readData = rd_val_s;
        end
    endgenerate

    scoreboard_regs #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .CLK     (CLK),
        .RST     (RST),
        .set_en  (issue_valid),
        .set_idx (issue_rd),
        .clr_en  (RegWrite),
        .clr_idx (writeReg),
        .busy    (busy_s)
    );

endmodule

// File: tb/tb_banco_registros_param.sv
// Bench for banco_registros_param: one combinational-read and one registered-read
// instance share stimulus and are checked against an array/queue-level model.
module tb_banco_registros_param;

    logic             clk;
    logic             rst;
    logic [1:0][4:0]  read_reg;
    logic [1:0][31:0] read_data0;
    logic [1:0][31:0] read_data1;
    logic [1:0]       rs_busy0;
    logic [1:0]       rs_busy1;
    logic             reg_write;
    logic [4:0]       write_reg;
    logic [31:0]      write_data;
    logic             issue_valid;
    logic [4:0]       issue_rd;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    logic [31:0] m_rd1 [2];

    banco_registros_param #(.XLEN(32), .NREGS(32), .NRD(2), .READ_REG(0)) dut0 (
        .CLK(clk), .RST(rst), .readReg(read_reg), .readData(read_data0),
        .RegWrite(reg_write), .writeReg(write_reg), .writeData(write_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs_busy(rs_busy0)
    );

    banco_registros_param #(.XLEN(32), .NREGS(32), .NRD(2), .READ_REG(1)) dut1 (
        .CLK(clk), .RST(rst), .readReg(read_reg), .readData(read_data1),
        .RegWrite(reg_write), .writeReg(write_reg), .writeData(write_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rs_busy(rs_busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_read(int p);
        logic [4:0] a;
        a = read_reg[p];
        if (a == 5'd0) return 32'd0;
        if (reg_write && (write_reg == a)) return write_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(int p);
        logic [4:0] a;
        a = read_reg[p];
        return m_busy[a] && !(reg_write && (write_reg == a));
    endfunction

    task automatic set_idle();
        rst = 1'b0; reg_write = 1'b0; write_reg = 5'd0; write_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 5'd0;
    endtask

    // one rising edge; model updated from the inputs held across it
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin m_mem[r] = 32'd0; m_busy[r] = 1'b0; end
            m_rd1[0] = 32'd0; m_rd1[1] = 32'd0;
        end else begin
            m_rd1[0] = exp_read(0);
            m_rd1[1] = exp_read(1);
            if (reg_write) begin
                if (write_reg != 5'd0) m_mem[write_reg] = write_data;
                m_busy[write_reg] = 1'b0;
            end
            if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; reg_write = 1'b1; write_reg = 5'd6; write_data = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd6; read_reg[0] = 5'd0; read_reg[1] = 5'd0;
        tick();
        set_idle();
        for (int a = 0; a < 32; a++) begin
            read_reg[0] = 5'(a);
            read_reg[1] = 5'(31 - a);
            #1;
            n_checks++;
            if (read_data0 !== 64'd0) begin
                n_errors++; $display("FAIL reset_rd0 x%0d: got %h expected 0", a, read_data0);
            end
            n_checks++;
            if (read_data1 !== 64'd0) begin
                n_errors++; $display("FAIL reset_rd1 x%0d: got %h expected 0", a, read_data1);
            end
            n_checks++;
            if ({rs_busy1, rs_busy0} !== 4'b0000) begin
                n_errors++; $display("FAIL reset_busy x%0d: got %b/%b expected 00/00", a, rs_busy0, rs_busy1);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        set_idle();
        reg_write = 1'b1; write_reg = 5'd5; write_data = 32'hDEAD_BEEF;
        read_reg[0] = 5'd0; read_reg[1] = 5'd0;
        tick();
        set_idle(); read_reg[0] = 5'd5;
        #1; n_checks++;
        if (read_data0[0] !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL wr_rd0: got %h expected deadbeef", read_data0[0]);
        end
        tick();
        #1; n_checks++;
        if (read_data1[0] !== 32'hDEAD_BEEF) begin
            n_errors++; $display("FAIL wr_rd1: got %h expected deadbeef", read_data1[0]);
        end
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h0000_1234; read_reg[0] = 5'd0;
        #1; n_checks++;
        if (read_data0[0] !== 32'd0) begin
            n_errors++; $display("FAIL x0_bypass: got %h expected 0", read_data0[0]);
        end
        tick();
        set_idle();
        #1; n_checks++;
        if (read_data0[0] !== 32'd0 || read_data1[0] !== 32'd0) begin
            n_errors++; $display("FAIL x0_write: got %h/%h expected 0/0", read_data0[0], read_data1[0]);
        end
        tick();
    endtask

    task automatic test_bypass();
        set_idle();
        reg_write = 1'b1; write_reg = 5'd7; write_data = 32'hA5A5_A5A5;
        read_reg[0] = 5'd5; read_reg[1] = 5'd7;
        #1; n_checks++;
        if (read_data0[1] !== 32'hA5A5_A5A5) begin
            n_errors++; $display("FAIL bypass_comb: got %h expected a5a5a5a5", read_data0[1]);
        end
        n_checks++;
        if (read_data1[1] !== m_rd1[1]) begin
            n_errors++; $display("FAIL bypass_reg_early: got %h expected %h", read_data1[1], m_rd1[1]);
        end
        tick();
        set_idle();
        #1; n_checks++;
        if (read_data1[1] !== 32'hA5A5_A5A5) begin
            n_errors++; $display("FAIL bypass_reg: got %h expected a5a5a5a5", read_data1[1]);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        set_idle();
        issue_valid = 1'b1; issue_rd = 5'd3; read_reg[0] = 5'd3; read_reg[1] = 5'd0;
        #1; n_checks++;
        if (rs_busy0[0] !== 1'b0) begin
            n_errors++; $display("FAIL sb_pre_issue: got %b expected 0", rs_busy0[0]);
        end
        tick();
        set_idle();
        for (int k = 0; k < 2; k++) begin
            #1; n_checks++;
            if (rs_busy0[0] !== 1'b1 || rs_busy1[0] !== 1'b1) begin
                n_errors++; $display("FAIL sb_pending: got %b/%b expected 1/1", rs_busy0[0], rs_busy1[0]);
            end
            tick();
        end
        reg_write = 1'b1; write_reg = 5'd3; write_data = $urandom;
        #1; n_checks++;
        if (rs_busy0[0] !== 1'b0 || rs_busy1[0] !== 1'b0) begin
            n_errors++; $display("FAIL sb_write_cycle: got %b/%b expected 0/0", rs_busy0[0], rs_busy1[0]);
        end
        tick();
        set_idle();
        #1; n_checks++;
        if (rs_busy0[0] !== 1'b0 || rs_busy1[0] !== 1'b0) begin
            n_errors++; $display("FAIL sb_after_write: got %b/%b expected 0/0", rs_busy0[0], rs_busy1[0]);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [31:0] wd;
        wd = $urandom;
        set_idle();
        issue_valid = 1'b1; issue_rd = 5'd4; reg_write = 1'b1; write_reg = 5'd4; write_data = wd;
        read_reg[0] = 5'd4; read_reg[1] = 5'd4;
        tick();
        set_idle();
        #1; n_checks++;
        if (rs_busy0 !== 2'b11 || rs_busy1 !== 2'b11) begin
            n_errors++; $display("FAIL simul_set_wins: got %b/%b expected 11/11", rs_busy0, rs_busy1);
        end
        n_checks++;
        if (read_data0[0] !== wd || read_data0[1] !== wd) begin
            n_errors++; $display("FAIL simul_data: got %h/%h expected %h", read_data0[0], read_data0[1], wd);
        end
        reg_write = 1'b1; write_reg = 5'd4; write_data = wd;
        tick();
        set_idle();
        issue_valid = 1'b1; issue_rd = 5'd0; read_reg[0] = 5'd0; read_reg[1] = 5'd0;
        tick();
        set_idle();
        #1; n_checks++;
        if (rs_busy0 !== 2'b00 || rs_busy1 !== 2'b00) begin
            n_errors++; $display("FAIL issue_x0: got %b/%b expected 00/00", rs_busy0, rs_busy1);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        set_idle();
        issue_valid = 1'b1; issue_rd = 5'd9; reg_write = 1'b1; write_reg = 5'd9; write_data = 32'h0000_0055;
        read_reg[0] = 5'd9; read_reg[1] = 5'd12;
        tick();
        issue_rd = 5'd12; reg_write = 1'b0;
        tick();
        set_idle();
        #1; n_checks++;
        if (rs_busy0 !== 2'b11) begin
            n_errors++; $display("FAIL midrst_pending: got %b expected 11", rs_busy0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1; n_checks++;
            if (read_data0 !== 64'd0 || read_data1 !== 64'd0 || rs_busy0 !== 2'b00 || rs_busy1 !== 2'b00) begin
                n_errors++; $display("FAIL midrst_after: got %h %h %b %b expected all 0",
                                     read_data0, read_data1, rs_busy0, rs_busy1);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 63) == 0);
            reg_write   = $urandom_range(0, 1);
            write_reg   = 5'($urandom_range(0, 15));
            write_data  = $urandom;
            issue_valid = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 15));
            for (int p = 0; p < 2; p++) begin
                read_reg[p] = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 15));
            end
            #1;
            for (int p = 0; p < 2; p++) begin
                n_checks++;
                if (read_data0[p] !== exp_read(p)) begin
                    n_errors++; $display("FAIL rand_rd0[%0d] c%0d: got %h expected %h", p, c, read_data0[p], exp_read(p));
                end
                n_checks++;
                if (read_data1[p] !== m_rd1[p]) begin
                    n_errors++; $display("FAIL rand_rd1[%0d] c%0d: got %h expected %h", p, c, read_data1[p], m_rd1[p]);
                end
                n_checks++;
                if (rs_busy0[p] !== exp_busy(p) || rs_busy1[p] !== exp_busy(p)) begin
                    n_errors++; $display("FAIL rand_busy[%0d] c%0d: got %b/%b expected %b",
                                         p, c, rs_busy0[p], rs_busy1[p], exp_busy(p));
                end
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        read_reg[0] = 5'd0; read_reg[1] = 5'd0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
